// File: rtl/aux_periph_responder.sv
// aux_periph_responder: target end of the CPU aux bus.
// Two-stage request pipeline (hold, then commit unless aborted) in front of the
// board peripherals: LEDs, seven-segment, timer with compare flag, and a UART
// transmitter fed by a small FIFO. Every non-aborted read is answered.
module aux_periph_responder #(
    parameter int unsigned UART_DIV_RESET = 434,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_aux_request,
    input  logic [31:0] cpu_aux_addr,
    input  logic        cpu_aux_write,
    input  logic [3:0]  cpu_aux_wstrb,
    input  logic [31:0] cpu_aux_wdata,
    input  logic        cpu_aux_abort,
    output logic        cpu_aux_rvalid,
    output logic [31:0] cpu_aux_rdata,
    output logic [8:0]  cpu_aux_rtag,
    output logic [9:0]  leds,
    output logic [23:0] seven_seg,
    output logic        timer_irq,
    output logic        uart_tx
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        REG_LEDR        = 3'd0,
        REG_SEVEN_SEG   = 3'd1,
        REG_TIMER_COUNT = 3'd2,
        REG_TIMER_CMP   = 3'd3,
        REG_TIMER_FLAG  = 3'd4,
        REG_UART_TX     = 3'd5,
        REG_UART_STAT   = 3'd6,
        REG_UART_DIV    = 3'd7
    } reg_sel_e;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    // Request hold stage
    logic        hold_valid_q, hold_valid_d;
    reg_sel_e    hold_addr_q, hold_addr_d;
    logic        hold_write_q, hold_write_d;
    logic [3:0]  hold_wstrb_q, hold_wstrb_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;

    // Read response
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [8:0]  rtag_q, rtag_d;

    // Peripheral registers
    logic [9:0]  leds_q, leds_d;
    logic [23:0] seg_q, seg_d;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        flag_q, flag_d;
    logic [15:0] div_q, div_d;

    // UART FIFO and transmitter
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic [PTR_W-1:0] fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    uart_state_e      state_q, state_d;
    logic [15:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic        commit, wr_en, rd_en;
    logic        push_req, fifo_push, fifo_pop;
    logic        fifo_empty, fifo_full, tx_busy;
    logic [31:0] wmerge, read_data;
    logic [15:0] eff_div, bit_reload;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{cpu_aux_addr[31:5], cpu_aux_addr[1:0]};

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
    assign tx_busy    = (state_q != UART_IDLE);
    assign eff_div    = (div_q == '0) ? 16'd1 : div_q;
    assign bit_reload = eff_div - 16'd1;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Register read mux, sampled in the commit cycle
    always_comb begin
        read_data = '0;
        case (hold_addr_q)
            REG_LEDR:        read_data = {22'd0, leds_q};
            REG_SEVEN_SEG:   read_data = {8'd0, seg_q};
            REG_TIMER_COUNT: read_data = count_q;
            REG_TIMER_CMP:   read_data = cmp_q;
            REG_TIMER_FLAG:  read_data = {31'd0, flag_q};
            REG_UART_TX:     read_data = 32'(FIFO_DEPTH) - 32'(fifo_cnt_q);
            REG_UART_STAT:   read_data = {29'd0, tx_busy, fifo_full, fifo_empty};
            REG_UART_DIV:    read_data = {16'd0, div_q};
            default:         read_data = '0;
        endcase
    end

    // Hold stage, commit/abort decision, register writes and timer
    always_comb begin
        hold_valid_d = cpu_aux_request;
        hold_addr_d  = reg_sel_e'(cpu_aux_addr[4:2]);
        hold_write_d = cpu_aux_write;
        hold_wstrb_d = cpu_aux_wstrb;
        hold_wdata_d = cpu_aux_wdata;

        commit = hold_valid_q && !cpu_aux_abort;
        wr_en  = commit && hold_write_q;
        rd_en  = commit && !hold_write_q;

        rvalid_d = rd_en;
        rdata_d  = rdata_q;
        rtag_d   = rtag_q;
        if (rd_en) begin
            rdata_d = read_data;
            rtag_d  = hold_wdata_q[8:0];
        end

        leds_d   = leds_q;
        seg_d    = seg_q;
        cmp_d    = cmp_q;
        div_d    = div_q;
        count_d  = count_q + 32'd1;
        flag_d   = flag_q;
        push_req = 1'b0;
        wmerge   = '0;

        if (wr_en) begin
            case (hold_addr_q)
                REG_LEDR: begin
                    wmerge = merge_bytes({22'd0, leds_q}, hold_wdata_q, hold_wstrb_q);
                    leds_d = wmerge[9:0];
                end
                REG_SEVEN_SEG: begin
                    wmerge = merge_bytes({8'd0, seg_q}, hold_wdata_q, hold_wstrb_q);
                    seg_d  = wmerge[23:0];
                end
                REG_TIMER_CMP: begin
                    cmp_d = merge_bytes(cmp_q, hold_wdata_q, hold_wstrb_q);
                end
                REG_TIMER_FLAG: begin
                    if (hold_wstrb_q[0] && hold_wdata_q[0]) flag_d = 1'b0;
                end
                REG_UART_TX: begin
                    push_req = hold_wstrb_q[0];
                end
                REG_UART_DIV: begin
                    wmerge = merge_bytes({16'd0, div_q}, hold_wdata_q, hold_wstrb_q);
                    div_d  = wmerge[15:0];
                end
                default: ;
            endcase
        end

        // A compare match on the same cycle as a clear keeps the flag set.
        if (count_q == cmp_q) flag_d = 1'b1;
    end

    // UART transmitter FSM and FIFO bookkeeping
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;

        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_mem_q[fifo_rd_ptr_q];
                    state_d   = UART_START;
                    bit_cnt_d = bit_reload;
                    tx_d      = 1'b0;
                end
            end
            UART_START: begin
                if (bit_cnt_q == '0) begin
                    state_d   = UART_DATA;
                    bit_idx_d = '0;
                    bit_cnt_d = bit_reload;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            UART_DATA: begin
                if (bit_cnt_q == '0) begin
                    bit_cnt_d = bit_reload;
                    if (bit_idx_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            UART_STOP: begin
                if (bit_cnt_q == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_mem_q[fifo_rd_ptr_q];
                        state_d   = UART_START;
                        bit_cnt_d = bit_reload;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = UART_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: state_d = UART_IDLE;
        endcase

        // Pop decisions use the registered count, so a fresh push is never bypassed.
        fifo_push     = push_req && (!fifo_full || fifo_pop);
        fifo_wr_ptr_d = fifo_push ? fifo_wr_ptr_q + PTR_W'(1) : fifo_wr_ptr_q;
        fifo_rd_ptr_d = fifo_pop  ? fifo_rd_ptr_q + PTR_W'(1) : fifo_rd_ptr_q;
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // FIFO storage; flushing is done by clearing pointers and count
    always_ff @(posedge clock) begin
        if (fifo_push) fifo_mem_q[fifo_wr_ptr_q] <= hold_wdata_q[7:0];
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_q  <= 1'b0;
            hold_addr_q   <= REG_LEDR;
            hold_write_q  <= 1'b0;
            hold_wstrb_q  <= '0;
            hold_wdata_q  <= '0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rtag_q        <= '0;
            leds_q        <= '0;
            seg_q         <= '0;
            count_q       <= '0;
            cmp_q         <= '1;
            flag_q        <= 1'b0;
            div_q         <= 16'(UART_DIV_RESET);
            fifo_wr_ptr_q <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_cnt_q    <= '0;
            state_q       <= UART_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            tx_q          <= 1'b1;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_addr_q   <= hold_addr_d;
            hold_write_q  <= hold_write_d;
            hold_wstrb_q  <= hold_wstrb_d;
            hold_wdata_q  <= hold_wdata_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rtag_q        <= rtag_d;
            leds_q        <= leds_d;
            seg_q         <= seg_d;
            count_q       <= count_d;
            cmp_q         <= cmp_d;
            flag_q        <= flag_d;
            div_q         <= div_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            tx_q          <= tx_d;
        end
    end

    assign cpu_aux_rvalid = rvalid_q;
    assign cpu_aux_rdata  = rdata_q;
    assign cpu_aux_rtag   = rtag_q;
    assign leds           = leds_q;
    assign seven_seg      = seg_q;
    assign timer_irq      = flag_q;
    assign uart_tx        = tx_q;

endmodule

// File: tb/tb_aux_periph_responder.sv
// Scoreboard bench for aux_periph_responder: stimulus pushes expected read
// responses, a negedge monitor pops and compares whenever rvalid is seen.
module tb_aux_periph_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_aux_request;
    logic [31:0] cpu_aux_addr;
    logic        cpu_aux_write;
    logic [3:0]  cpu_aux_wstrb;
    logic [31:0] cpu_aux_wdata;
    logic        cpu_aux_abort;
    logic        cpu_aux_rvalid;
    logic [31:0] cpu_aux_rdata;
    logic [8:0]  cpu_aux_rtag;
    logic [9:0]  leds;
    logic [23:0] seven_seg;
    logic        timer_irq;
    logic        uart_tx;

    always #5 clock = ~clock;

    aux_periph_responder #(
        .UART_DIV_RESET(434),
        .FIFO_DEPTH(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_aux_request(cpu_aux_request),
        .cpu_aux_addr(cpu_aux_addr),
        .cpu_aux_write(cpu_aux_write),
        .cpu_aux_wstrb(cpu_aux_wstrb),
        .cpu_aux_wdata(cpu_aux_wdata),
        .cpu_aux_abort(cpu_aux_abort),
        .cpu_aux_rvalid(cpu_aux_rvalid),
        .cpu_aux_rdata(cpu_aux_rdata),
        .cpu_aux_rtag(cpu_aux_rtag),
        .leds(leds),
        .seven_seg(seven_seg),
        .timer_irq(timer_irq),
        .uart_tx(uart_tx)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [8:0]  rtag;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned mcount = 0;
    logic        tx_exp [40];
    int unsigned c0;
    logic        seen;

    // Cycle count since reset release, used to predict the timer
    always @(posedge clock) mcount <= reset ? 0 : mcount + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Present one request for one cycle; reads queue their expected response
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] strb,
                         input logic [31:0] wdata, input logic [31:0] exp, input string name);
        cpu_aux_request = 1'b1;
        cpu_aux_addr    = addr;
        cpu_aux_write   = wr;
        cpu_aux_wstrb   = strb;
        cpu_aux_wdata   = wdata;
        if (!wr) exp_q.push_back('{rdata: exp, rtag: wdata[8:0], name: name});
        @(negedge clock);
        cpu_aux_request = 1'b0;
    endtask

    // Response monitor
    always @(negedge clock) begin
        if (cpu_aux_rvalid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rvalid: got rdata=0x%08h rtag=0x%03h, required no response",
                         cpu_aux_rdata, cpu_aux_rtag);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_rdata"}, cpu_aux_rdata, mon_e.rdata);
                check({mon_e.name, "_rtag"}, {23'd0, cpu_aux_rtag}, {23'd0, mon_e.rtag});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        cpu_aux_request = 1'b0;
        cpu_aux_addr    = '0;
        cpu_aux_write   = 1'b0;
        cpu_aux_wstrb   = '0;
        cpu_aux_wdata   = '0;
        cpu_aux_abort   = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_rvalid", {31'd0, cpu_aux_rvalid}, 32'd0);
        check("rst_rdata", cpu_aux_rdata, 32'd0);
        check("rst_rtag", {23'd0, cpu_aux_rtag}, 32'd0);
        check("rst_leds", {22'd0, leds}, 32'd0);
        check("rst_seg", {8'd0, seven_seg}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        check("rst_tx", {31'd0, uart_tx}, 32'd1);
        reset = 1'b0;
        @(negedge clock);

        issue(32'h0C, 1'b0, 4'b0000, 32'h011, 32'hFFFF_FFFF, "rst_cmp");
        issue(32'h1C, 1'b0, 4'b0000, 32'h012, 32'd434, "rst_div");
        issue(32'h18, 1'b0, 4'b0000, 32'h013, 32'h1, "rst_stat");
        issue(32'h14, 1'b0, 4'b0000, 32'h014, 32'd8, "rst_free");

        // LEDs: only byte 0 strobed
        issue(32'h00, 1'b1, 4'b0001, 32'h3FF, 32'd0, "");
        @(negedge clock);
        check("leds_strobe", {22'd0, leds}, 32'h0FF);
        issue(32'h00, 1'b0, 4'b0000, 32'h1A5, 32'h0FF, "ledr_read");
        issue(32'h1234_5660, 1'b0, 4'b0000, 32'h0C3, 32'h0FF, "ledr_alias");

        // Aborted read and write
        cpu_aux_request = 1'b1; cpu_aux_addr = 32'h04; cpu_aux_write = 1'b0; cpu_aux_wdata = 32'h1FF;
        @(negedge clock);
        cpu_aux_request = 1'b0; cpu_aux_abort = 1'b1;
        @(negedge clock);
        cpu_aux_abort = 1'b0;
        cpu_aux_request = 1'b1; cpu_aux_addr = 32'h04; cpu_aux_write = 1'b1;
        cpu_aux_wstrb = 4'b1111; cpu_aux_wdata = 32'h0012_3456;
        @(negedge clock);
        cpu_aux_request = 1'b0; cpu_aux_abort = 1'b1;
        @(negedge clock);
        cpu_aux_abort = 1'b0;
        @(negedge clock);
        check("abort_write_seg", {8'd0, seven_seg}, 32'd0);

        // Abort hits only the held request, not the one presented alongside it
        cpu_aux_request = 1'b1; cpu_aux_addr = 32'h00; cpu_aux_write = 1'b0; cpu_aux_wdata = 32'h011;
        @(negedge clock);
        cpu_aux_addr = 32'h04; cpu_aux_wdata = 32'h022; cpu_aux_abort = 1'b1;
        exp_q.push_back('{rdata: 32'd0, rtag: 9'h022, name: "after_abort"});
        @(negedge clock);
        cpu_aux_request = 1'b0; cpu_aux_abort = 1'b0;
        repeat (3) @(negedge clock);

        // Seven-seg byte strobes; byte 3 is beyond the register
        issue(32'h04, 1'b1, 4'b1101, 32'hAABB_CCDD, 32'd0, "");
        issue(32'h04, 1'b0, 4'b0000, 32'h07E, 32'h00BB_00DD, "seg_read");
        @(negedge clock);
        check("seg_strobe", {8'd0, seven_seg}, 32'h00BB_00DD);

        // Timer compare at 100
        issue(32'h0C, 1'b1, 4'b1111, 32'd100, 32'd0, "");
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            if (timer_irq) seen = 1'b1;
            else @(negedge clock);
        end
        check("irq_seen", {31'd0, seen}, 32'd1);
        check("irq_rise_cycle", mcount, 32'd101);
        issue(32'h08, 1'b0, 4'b0000, 32'h055, mcount + 1, "count_read");
        issue(32'h10, 1'b0, 4'b0000, 32'h056, 32'd1, "flag_read");
        issue(32'h10, 1'b1, 4'b0001, 32'd1, 32'd0, "");
        @(negedge clock);
        check("irq_cleared", {31'd0, timer_irq}, 32'd0);

        // Clear coinciding with a compare match
        c0 = mcount;
        issue(32'h0C, 1'b1, 4'b1111, c0 + 10, 32'd0, "");
        for (int k = 0; k < 20 && mcount != c0 + 9; k++) @(negedge clock);
        check("irq_before_match", {31'd0, timer_irq}, 32'd0);
        issue(32'h10, 1'b1, 4'b0001, 32'd1, 32'd0, "");
        @(negedge clock);
        check("set_wins", {31'd0, timer_irq}, 32'd1);
        repeat (3) @(negedge clock);
        check("set_holds", {31'd0, timer_irq}, 32'd1);

        // UART frame of 0x55 at 4 clocks per bit
        for (int i = 0; i < 4; i++) tx_exp[i] = 1'b0;
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < 4; j++) tx_exp[4 + 4*b + j] = (b % 2 == 0) ? 1'b1 : 1'b0;
        for (int i = 36; i < 40; i++) tx_exp[i] = 1'b1;
        issue(32'h1C, 1'b1, 4'b0011, 32'd4, 32'd0, "");
        issue(32'h14, 1'b1, 4'b0001, 32'h55, 32'd0, "");
        repeat (2) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            check($sformatf("tx_bit%0d", i), {31'd0, uart_tx}, {31'd0, tx_exp[i]});
            if (i == 10) begin
                cpu_aux_request = 1'b1; cpu_aux_addr = 32'h18; cpu_aux_write = 1'b0; cpu_aux_wdata = 32'h0A0;
                exp_q.push_back('{rdata: 32'h5, rtag: 9'h0A0, name: "stat_busy"});
            end else begin
                cpu_aux_request = 1'b0;
            end
            @(negedge clock);
        end
        check("tx_idle_after", {31'd0, uart_tx}, 32'd1);
        issue(32'h18, 1'b0, 4'b0000, 32'h0A1, 32'h1, "stat_idle");

        // Slow divisor, ten back-to-back pushes: one shifting, eight queued, one dropped
        issue(32'h1C, 1'b1, 4'b0011, 32'd1000, 32'd0, "");
        for (int i = 0; i < 10; i++) issue(32'h14, 1'b1, 4'b0001, 32'h30 + i, 32'd0, "");
        issue(32'h18, 1'b0, 4'b0000, 32'h0B0, 32'h6, "stat_full");
        issue(32'h14, 1'b0, 4'b0000, 32'h0B1, 32'd0, "free_full");
        repeat (4) @(negedge clock);

        // Reset mid-transmission with three bytes queued and reads in flight
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        issue(32'h1C, 1'b1, 4'b0011, 32'd20, 32'd0, "");
        for (int i = 0; i < 4; i++) issue(32'h14, 1'b1, 4'b0001, 32'h00, 32'd0, "");
        repeat (40) @(negedge clock);
        check("tx_low_in_data", {31'd0, uart_tx}, 32'd0);
        issue(32'h18, 1'b0, 4'b0000, 32'h0C0, 32'h4, "stat_queued");
        repeat (3) @(negedge clock);
        cpu_aux_request = 1'b1; cpu_aux_addr = 32'h00; cpu_aux_write = 1'b0; cpu_aux_wdata = 32'h0AA;
        @(negedge clock);
        cpu_aux_addr = 32'h04; cpu_aux_wdata = 32'h0BB; reset = 1'b1;
        @(negedge clock);
        cpu_aux_request = 1'b0; reset = 1'b0;
        check("tx_high_after_reset", {31'd0, uart_tx}, 32'd1);
        check("leds_after_reset", {22'd0, leds}, 32'd0);
        check("seg_after_reset", {8'd0, seven_seg}, 32'd0);
        check("irq_after_reset", {31'd0, timer_irq}, 32'd0);
        repeat (3) @(negedge clock);
        issue(32'h18, 1'b0, 4'b0000, 32'h0D0, 32'h1, "stat_flushed");
        issue(32'h14, 1'b0, 4'b0000, 32'h0D1, 32'd8, "free_flushed");
        issue(32'h1C, 1'b0, 4'b0000, 32'h0D2, 32'd434, "div_after_reset");
        repeat (30) @(negedge clock);
        check("tx_stays_idle", {31'd0, uart_tx}, 32'd1);

        check("pending_responses", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aux_periph_responder.md
Name: aux_periph_responder

Overview:
- Target end of the CPU aux bus. Accepts the CPU's aux requests, commits writes, and returns read data with the echoed tag.
- Holds the board-level peripheral registers: LEDs, seven-segment, a free-running timer with compare flag, and a UART transmitter with an 8-entry FIFO.
- Owns the whole aux address space and answers every read, so the CPU readpath never hangs.

Parameters:
- UART_DIV_RESET, 434: reset value of the UART bit divisor (clocks per bit).
- FIFO_DEPTH, 8: UART TX FIFO entries (power of 2).

Ports:
- clock, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- cpu_aux_request, input, 1: request valid this cycle.
- cpu_aux_addr, input, 32: byte address.
- cpu_aux_write, input, 1: 1=write, 0=read.
- cpu_aux_wstrb, input, 4: byte enables for writes.
- cpu_aux_wdata, input, 32: write data; on reads, bits [8:0] carry the tag.
- cpu_aux_abort, input, 1: cancels the request presented the previous cycle.
- cpu_aux_rvalid, output, 1: read data valid.
- cpu_aux_rdata, output, 32: read data.
- cpu_aux_rtag, output, 9: returned tag.
- leds, output, 10: LED register.
- seven_seg, output, 24: seven-segment register.
- timer_irq, output, 1: timer flag.
- uart_tx, output, 1: serial out, idle high.

Behaviour:
- Reset values:
  - rvalid=0, rdata=0, rtag=0.
  - leds=0, seven_seg=0, timer count=0, TIMER_CMP=0xFFFFFFFF, flag=0.
  - FIFO empty, UART idle, uart_tx=1, UART_DIV=UART_DIV_RESET.
- Pipeline:
  - Cycle N: request sampled into a hold stage (addr, write, wstrb, wdata).
  - Cycle N+1: abort is sampled against the held request. If abort=1, the request is discarded with no side effect and no rvalid.
  - Otherwise the request commits at the end of N+1. For a read, rvalid=1 for exactly one cycle during N+2, with rtag=held wdata[8:0].
- Throughput: one request per cycle, fully pipelined, no stall. Abort only ever refers to the request held from the previous cycle.
- Decode uses addr[4:2]; higher address bits are ignored.
- Register map:
  - 0x00 LEDR: RW, 10 bits.
  - 0x04 SEVEN_SEG: RW, 24 bits.
  - 0x08 TIMER_COUNT: RO. 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF->0.
  - 0x0C TIMER_CMP: RW, 32 bits.
  - 0x10 TIMER_FLAG: bit0. Set when count==CMP. Writing 1 to bit0 with wstrb[0] clears it. If set and clear happen in the same cycle, set wins.
  - 0x14 UART_TX: a write with wstrb[0] pushes wdata[7:0]. A read returns the free FIFO entries (0..FIFO_DEPTH).
  - 0x18 UART_STAT: bit0 fifo_empty, bit1 fifo_full, bit2 tx_busy. RO.
  - 0x1C UART_DIV: RW, 16 bits. A value of 0 is treated as 1.
- Write rules:
  - Writes to RW registers honour wstrb per byte; strobe bits beyond a register's width are ignored.
  - Writes to RO registers are ignored.
  - Read data has upper unused bits = 0.
  - Reads sample register state at the commit cycle.
- FIFO:
  - Push while full is dropped silently.
  - Push and pop in the same cycle while full is accepted; count stays the same.
  - Pop and push on an empty FIFO do not bypass: the pushed byte is popped no earlier than the next cycle.
- UART transmitter:
  - States: IDLE, START, DATA, STOP. Each state bit lasts UART_DIV clocks.
  - IDLE -> START when the FIFO is non-empty; the byte is popped on that transition.
  - DATA sends 8 bits LSB first.
  - STOP -> START directly if the FIFO is non-empty, otherwise STOP -> IDLE.
  - tx_busy=1 in every state except IDLE.
  - The divisor is sampled at the start of each bit.
- Reset mid-operation:
  - Any pending held request is dropped with no rvalid.
  - uart_tx=1 in the cycle after reset is sampled, and the FIFO is flushed.

Test Plan:
- Write 0x00 wdata=0x3FF wstrb=0001 -> leds=0x0FF. Then read 0x00 with wdata[8:0]=0x1A5 -> rvalid at N+2, rdata=0x0FF, rtag=0x1A5.
- Read 0x04 with cpu_aux_abort=1 at N+1 -> no rvalid. Write 0x04 wdata=0x123456 wstrb=1111 with abort -> seven_seg stays 0.
- After reset, write TIMER_CMP=100 -> timer_irq=1 once count reaches 100. Write 0x10 wdata=1 -> timer_irq=0. Clear coinciding with a match -> flag stays 1.
- UART_DIV=4, push 0x55 -> uart_tx: 4 clocks low, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 4 clocks high. 40 clocks total; tx_busy then returns to 0.
- UART_DIV=1000, push 10 bytes on consecutive cycles -> first byte enters the shifter, next 8 fill the FIFO, 10th is dropped. UART_STAT=0x6, UART_TX read=0.
- Assert reset during the DATA state with 3 bytes queued -> next cycle uart_tx=1, UART_STAT=0x1, back-to-back reads in flight produce no rvalid.
